// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory arbiter slice.
// Used by mem_arb_pick and mem_arbiter (see MEM_ARB_RR_EN in those files).
package mem_pkg;

   localparam int WIDTH_DEF      = 32;
   localparam int WIDTH_BITS_DEF = 16;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      LS   = 2'd2
   } rd_owner_t;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two-port memory arbiter.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed LS priority with IF anti-starvation.
module mem_arb_pick
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic        if_req,
   input  logic        ls_req,
   input  lock_state_t lock_state,
`ifdef MEM_ARB_RR_EN
   input  logic        rr_ptr,
`else
   input  logic [3:0]  wait_cnt,
`endif
   output logic [1:0]  gnt
);

   logic if_first;

`ifdef MEM_ARB_RR_EN
   assign if_first = (rr_ptr == 1'b0);
`else
   assign if_first = (wait_cnt == 4'(MAX_WAIT));
`endif

   // gnt[0] = IF, gnt[1] = LS
   always_comb begin
      gnt = 2'b00;
      if (lock_state == LOCKED) begin
         gnt[1] = ls_req;
      end else if (if_req && ls_req) begin
         gnt = if_first ? 2'b01 : 2'b10;
      end else begin
         gnt = {ls_req, if_req};
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LS priority.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int WIDTH_BITS = WIDTH_BITS_DEF,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [WIDTH_BITS-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [WIDTH-1:0]      if_rdata,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic                  ls_lock,
   input  logic [WIDTH_BITS-1:0] ls_addr,
   input  logic [WIDTH-1:0]      ls_wdata,
   output logic                  ls_gnt,
   output logic                  ls_rvalid,
   output logic [WIDTH-1:0]      ls_rdata,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [WIDTH_BITS-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata
);

   lock_state_t lock_q, lock_d;
   rd_owner_t   rd_owner_q, rd_owner_d;
   logic [1:0]  pick_gnt;

`ifdef MEM_ARB_RR_EN
   logic ptr_q, ptr_d;

   mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
      .if_req     (if_req),
      .ls_req     (ls_req),
      .lock_state (lock_q),
      .rr_ptr     (ptr_q),
      .gnt        (pick_gnt)
   );

   always_comb begin
      ptr_d = ptr_q;
      if (if_gnt)      ptr_d = 1'b1;
      else if (ls_gnt) ptr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end
`else
   logic [3:0] wait_cnt_q, wait_cnt_d;

   mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
      .if_req     (if_req),
      .ls_req     (ls_req),
      .lock_state (lock_q),
      .wait_cnt   (wait_cnt_q),
      .gnt        (pick_gnt)
   );

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (lock_q == LOCKED) begin
         wait_cnt_d = wait_cnt_q;
      end else if (!if_req || if_gnt) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < 4'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt_q <= 4'd0;
      else        wait_cnt_q <= wait_cnt_d;
   end
`endif

   // Grants are suppressed while reset is held so the memory sees no access.
   assign if_gnt = pick_gnt[0] & rst_n;
   assign ls_gnt = pick_gnt[1] & rst_n;

   always_comb begin
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_ren  = 1'b1;
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_ren   = !ls_we;
         mem_wen   = ls_we;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
      end
   end

   always_comb begin
      lock_d     = lock_q;
      rd_owner_d = NONE;
      case (lock_q)
         UNLOCKED: if (ls_gnt && ls_lock) lock_d = LOCKED;
         LOCKED:   if (!ls_req || (ls_gnt && !ls_lock)) lock_d = UNLOCKED;
         default:  lock_d = UNLOCKED;
      endcase
      if (if_gnt)                rd_owner_d = IF;
      else if (ls_gnt && !ls_we) rd_owner_d = LS;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q     <= UNLOCKED;
         rd_owner_q <= NONE;
      end else begin
         lock_q     <= lock_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   assign if_rvalid = (rd_owner_q == IF);
   assign ls_rvalid = (rd_owner_q == LS);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule
